// File: rtl/codec_sample_tx_pkg.sv
// codec_sample_tx_pkg: shared audio constants and I2S frame-length derivation
package codec_sample_tx_pkg;
  localparam int SAMPLE_W      = 16;
  localparam int SLOT_BITS_DEF = 32;
  localparam int I2S_DELAY     = 1;
  function automatic int frame_clks(input int clk_div, input int slot_bits);
    return 2 * clk_div * 2 * slot_bits;
  endfunction
endpackage

// File: rtl/codec_frame_timer.sv
// codec_frame_timer: free-running I2S frame counter with bclk/lrclk/slot decode
// Ports: clk, reset (async, active-low) in; frame_start (next t is 0),
// capture_strobe (t is LATCH_DELAY), slot_pos (slot position of next t),
// bclk/lrclk registered serial clocks out.
module codec_frame_timer import codec_sample_tx_pkg::*; #(
  parameter int CLK_DIV     = 4,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int LATCH_DELAY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         frame_start,
  output logic                         capture_strobe,
  output logic [$clog2(SLOT_BITS)-1:0] slot_pos,
  output logic                         bclk,
  output logic                         lrclk
);
  localparam int BIT_CLKS   = 2 * CLK_DIV;
  localparam int FRAME_CLKS = frame_clks(CLK_DIV, SLOT_BITS);
  localparam int TW         = $clog2(FRAME_CLKS);
  localparam int SW         = $clog2(SLOT_BITS);
  logic [TW-1:0] t_q, t_d;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d;
  int b_d;
  // everything is decoded from the next count so the registered clocks line up with t
  always_comb begin
    t_d            = (t_q == TW'(FRAME_CLKS - 1)) ? '0 : t_q + TW'(1);
    b_d            = int'(t_d) / BIT_CLKS;
    bclk_d         = (int'(t_d) % BIT_CLKS) >= CLK_DIV;
    lrclk_d        = b_d >= SLOT_BITS;
    slot_pos       = SW'(b_d % SLOT_BITS);
    frame_start    = t_d == '0;
    capture_strobe = t_q == TW'(LATCH_DELAY);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q     <= TW'(FRAME_CLKS - 1);
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      t_q     <= t_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end
  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;
endmodule

// File: rtl/codec_sample_tx.sv
// codec_sample_tx: paces the sample chain and serialises mono samples onto I2S
// Ports: clk, reset (async, active-low), tx_enable (sampled at frame start),
// sample_in in; new_sample_ready (one-clk request per frame), bclk, lrclk,
// sdata (MSB first, one-bit I2S delay, same data in both slots) out.
module codec_sample_tx import codec_sample_tx_pkg::*; #(
  parameter int CLK_DIV      = 4,
  parameter int SLOT_BITS    = SLOT_BITS_DEF,
  parameter int LATCH_DELAY  = 4,
  parameter int SAMPLE_WIDTH = SAMPLE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    new_sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata
);
  localparam int SW = $clog2(SLOT_BITS);
  logic frame_start, capture_strobe;
  logic [SW-1:0] slot_pos;
  logic en_q, en_d, nsr_q, nsr_d, sdata_q, sdata_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d, shifted;
  codec_frame_timer #(
    .CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS), .LATCH_DELAY(LATCH_DELAY)
  ) u_timer (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .capture_strobe(capture_strobe), .slot_pos(slot_pos),
    .bclk(bclk), .lrclk(lrclk)
  );
  // sdata uses next-state en/hold so a capture late in bit 0 still reaches the MSB slot
  always_comb begin
    en_d    = frame_start ? tx_enable : en_q;
    hold_d  = (capture_strobe && en_q) ? sample_in : hold_q;
    shifted = hold_d << (slot_pos - SW'(I2S_DELAY));
    sdata_d = en_d && int'(slot_pos) >= I2S_DELAY
              && int'(slot_pos) < SAMPLE_WIDTH + I2S_DELAY && shifted[SAMPLE_WIDTH-1];
    nsr_d   = frame_start && en_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= 1'b0;
      nsr_q   <= 1'b0;
      sdata_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      en_q    <= en_d;
      nsr_q   <= nsr_d;
      sdata_q <= sdata_d;
      hold_q  <= hold_d;
    end
  end
  assign new_sample_ready = nsr_q;
  assign sdata            = sdata_q;
endmodule

// File: tb/tb_codec_sample_tx.sv
// tb_codec_sample_tx: frame-table stimulus with a per-frame expectation scoreboard
module tb_codec_sample_tx;
  localparam int F  = 512;
  localparam int LD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_enable = 1'b0;
  logic [15:0] sample_in = '0;
  logic new_sample_ready, bclk, lrclk, sdata;
  int tt = F - 1;
  int checks = 0;
  int failures = 0;
  typedef struct packed {logic pulse; logic [15:0] word;} exp_t;
  typedef struct {
    logic en, mid, rst;
    logic [15:0] smp, late;
    logic pulse;
    logic [15:0] word;
  } row_t;
  exp_t q[$];
  exp_t cur;
  logic active = 1'b0;
  row_t rows[9];

  codec_sample_tx dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable), .sample_in(sample_in),
    .new_sample_ready(new_sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%b want=%b", name, tt, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) tt = F - 1;
    else tt = (tt + 1) % F;
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      active = 1'b0;
      chk("rst_nsr", new_sample_ready, 1'b0);
      chk("rst_bclk", bclk, 1'b0);
      chk("rst_lrclk", lrclk, 1'b0);
      chk("rst_sdata", sdata, 1'b0);
    end else begin
      if (tt == 0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          active = 1'b0;
          $display("FAIL sb_empty t=%0d got=empty want=entry", tt);
        end else begin
          cur = q.pop_front();
          active = 1'b1;
        end
      end
      if (active) begin
        int s;
        s = (tt / 8) % 32;
        chk("nsr", new_sample_ready, tt == 0 && cur.pulse);
        chk("bclk", bclk, (tt % 8) >= 4);
        chk("lrclk", lrclk, (tt / 8) >= 32);
        chk("sdata", sdata, (s >= 1 && s <= 16) ? cur.word[16 - s] : 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d got=timeout want=finish", tt);
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{1'b1, 1'b1, 1'b0, 16'hA5C3, 16'h0000, 1'b1, 16'hA5C3};
    rows[1] = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'hFFFF, 1'b1, 16'h1234};
    rows[2] = '{1'b1, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 16'h8000};
    rows[3] = '{1'b0, 1'b0, 1'b0, 16'h5555, 16'hAAAA, 1'b0, 16'h0000};
    rows[4] = '{1'b0, 1'b1, 1'b0, 16'h3333, 16'hCCCC, 1'b0, 16'h0000};
    rows[5] = '{1'b1, 1'b1, 1'b0, 16'h0001, 16'hFFFE, 1'b1, 16'h0001};
    rows[6] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF};
    rows[7] = '{1'b1, 1'b1, 1'b0, 16'h6E49, 16'h91B6, 1'b1, 16'h6E49};
    rows[8] = '{1'b1, 1'b1, 1'b0, 16'hA5C3, 16'h5A3C, 1'b1, 16'hA5C3};
    #1 reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do @(negedge clk); while (tt != F - 1);
      tx_enable = rows[i].en;
      sample_in = ~rows[i].smp;
      q.push_back('{rows[i].pulse, rows[i].word});
      reset = 1'b1;
      do @(negedge clk); while (tt != LD);
      sample_in = rows[i].smp;
      @(negedge clk);
      sample_in = rows[i].late;
      do @(negedge clk); while (tt != 100);
      tx_enable = rows[i].mid;
      if (rows[i].rst) begin
        do @(negedge clk); while (tt != 300);
        #1 reset = 1'b0;
        #1;
        chk("async_nsr", new_sample_ready, 1'b0);
        chk("async_bclk", bclk, 1'b0);
        chk("async_lrclk", lrclk, 1'b0);
        chk("async_sdata", sdata, 1'b0);
        repeat (3) @(negedge clk);
      end
    end
    do @(negedge clk); while (tt != F - 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
